// File: rtl/simple_isa_issue.sv
// Issue/writeback stage for the 8-bit add/subtract ALU: accepts one instruction at a time,
// reads operands from a 4x8 register file, waits ALU_LAT cycles, then retires and writes back.
module simple_isa_issue #(
    parameter int unsigned ALU_LAT      = 1,
    parameter logic [7:0]  RF_RESET_VAL = 8'h00
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic        alu_sub,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_o,
    output logic        retire_valid,
    output logic        retire_we,
    output logic [1:0]  retire_rd,
    output logic [7:0]  retire_data,
    input  logic [1:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    typedef enum logic [1:0] {IDLE, EXEC, WAIT, RETIRE} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_LDI, OP_NOP} opcode_t;

    localparam int unsigned WAIT_CYC  = (ALU_LAT > 1) ? ALU_LAT - 1 : 0;
    localparam logic [1:0]  WAIT_INIT = (WAIT_CYC > 0) ? 2'(WAIT_CYC - 1) : 2'd0;

    state_t      state;
    logic [7:0]  rf [4];
    logic [1:0]  rd_q;
    logic [1:0]  wait_cnt;
    logic        ret_alu;
    logic [7:0]  ret_imm;

    opcode_t     opcode;
    logic [1:0]  rd, rs1, rs2;
    logic [7:0]  imm;

    assign opcode = opcode_t'(instr[15:14]);
    assign rd     = instr[13:12];
    assign rs1    = instr[11:10];
    assign rs2    = instr[9:8];
    assign imm    = instr[7:0];

    // The ALU result only becomes valid in the RETIRE cycle itself, so it is forwarded
    // combinationally; LDI/NOP data comes from a register cleared outside RETIRE.
    assign retire_data = ret_alu ? alu_o : ret_imm;
    assign dbg_data    = rf[dbg_addr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            instr_ready  <= 1'b1;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_sub      <= 1'b0;
            rd_q         <= '0;
            wait_cnt     <= '0;
            ret_alu      <= 1'b0;
            ret_imm      <= '0;
            retire_valid <= 1'b0;
            retire_we    <= 1'b0;
            retire_rd    <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                rf[i] <= RF_RESET_VAL;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        instr_ready <= 1'b0;
                        case (opcode)
                            OP_ADD, OP_SUB: begin
                                alu_a   <= rf[rs1];
                                alu_b   <= rf[rs2];
                                alu_sub <= (opcode == OP_SUB);
                                rd_q    <= rd;
                                state   <= EXEC;
                            end
                            OP_LDI: begin
                                retire_valid <= 1'b1;
                                retire_we    <= 1'b1;
                                retire_rd    <= rd;
                                ret_imm      <= imm;
                                state        <= RETIRE;
                            end
                            default: begin
                                retire_valid <= 1'b1;
                                state        <= RETIRE;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    if (WAIT_CYC == 0) begin
                        retire_valid <= 1'b1;
                        retire_we    <= 1'b1;
                        retire_rd    <= rd_q;
                        ret_alu      <= 1'b1;
                        state        <= RETIRE;
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        retire_valid <= 1'b1;
                        retire_we    <= 1'b1;
                        retire_rd    <= rd_q;
                        ret_alu      <= 1'b1;
                        state        <= RETIRE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                RETIRE: begin
                    if (retire_we) begin
                        rf[retire_rd] <= retire_data;
                    end
                    retire_valid <= 1'b0;
                    retire_we    <= 1'b0;
                    retire_rd    <= '0;
                    ret_alu      <= 1'b0;
                    ret_imm      <= '0;
                    instr_ready  <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_isa_issue.sv
// Directed bench for simple_isa_issue: instruction table with hand-computed results,
// plus sequences for held instr_valid and reset during EXEC.
module tb_simple_isa_issue;

    logic        clk = 1'b0;
    logic        resetn;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        alu_sub;
    logic [7:0]  alu_a, alu_b, alu_o;
    logic        retire_valid, retire_we;
    logic [1:0]  retire_rd;
    logic [7:0]  retire_data;
    logic [1:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Single registered ALU stage (ALU_LAT = 1)
    always_ff @(posedge clk) begin
        alu_o <= alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
    end

    simple_isa_issue #(.ALU_LAT(1), .RF_RESET_VAL(8'h00)) dut (
        .clk(clk), .resetn(resetn),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .alu_sub(alu_sub), .alu_a(alu_a), .alu_b(alu_b), .alu_o(alu_o),
        .retire_valid(retire_valid), .retire_we(retire_we),
        .retire_rd(retire_rd), .retire_data(retire_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    typedef struct {
        logic [15:0] ins;
        int          lat;
        logic        sub;
        logic        we;
        logic [1:0]  rd;
        logic [7:0]  data;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rf(input string name, input logic [31:0] exp_rf);
        for (int r = 0; r < 4; r++) begin
            dbg_addr = 2'(r);
            #1;
            chk(name, {8'h00, dbg_data}, {8'h00, exp_rf[r*8 +: 8]});
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        @(negedge clk);
        instr       = v.ins;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_accept", {15'd0, instr_ready}, 16'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        if (v.lat == 2) begin
            chk("exec_ready", {15'd0, instr_ready}, 16'd0);
            chk("exec_alu_sub", {15'd0, alu_sub}, {15'd0, v.sub});
        end
        n = 1;
        while (!retire_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("retire_latency", 16'(n), 16'(v.lat));
        chk("retire_we", {15'd0, retire_we}, {15'd0, v.we});
        chk("retire_rd", {14'd0, retire_rd}, {14'd0, v.rd});
        chk("retire_data", {8'd0, retire_data}, {8'd0, v.data});
        @(negedge clk);
        chk("retire_pulse_end", {15'd0, retire_valid}, 16'd0);
        chk("ready_after_retire", {15'd0, instr_ready}, 16'd1);
        if (v.we) begin
            dbg_addr = v.rd;
            #1;
            chk("dbg_after_write", {8'd0, dbg_data}, {8'd0, v.data});
        end
    endtask

    vec_t        vecs[13];
    logic [6:0]  exp_rdy;
    logic [7:0]  ret_d[2];
    int          acc, rets;

    initial begin
        // {instr, latency, alu_sub in EXEC, we, rd, data}
        vecs[0]  = '{16'h9005, 1, 1'b0, 1'b1, 2'd1, 8'h05}; // LDI R1,05
        vecs[1]  = '{16'hA003, 1, 1'b0, 1'b1, 2'd2, 8'h03}; // LDI R2,03
        vecs[2]  = '{16'h3600, 2, 1'b0, 1'b1, 2'd3, 8'h08}; // ADD R3,R1,R2
        vecs[3]  = '{16'h9003, 1, 1'b0, 1'b1, 2'd1, 8'h03}; // LDI R1,03
        vecs[4]  = '{16'hA005, 1, 1'b0, 1'b1, 2'd2, 8'h05}; // LDI R2,05
        vecs[5]  = '{16'h4600, 2, 1'b1, 1'b1, 2'd0, 8'hFE}; // SUB R0,R1,R2
        vecs[6]  = '{16'h90FF, 1, 1'b0, 1'b1, 2'd1, 8'hFF}; // LDI R1,FF
        vecs[7]  = '{16'hA002, 1, 1'b0, 1'b1, 2'd2, 8'h02}; // LDI R2,02
        vecs[8]  = '{16'h1600, 2, 1'b0, 1'b1, 2'd1, 8'h01}; // ADD R1,R1,R2 (wrap)
        vecs[9]  = '{16'h2500, 2, 1'b0, 1'b1, 2'd2, 8'h02}; // ADD R2,R1,R1
        vecs[10] = '{16'hF5AA, 1, 1'b0, 1'b0, 2'd0, 8'h00}; // NOP, junk fields
        vecs[11] = '{16'h7000, 2, 1'b1, 1'b1, 2'd3, 8'h00}; // SUB R3,R0,R0
        vecs[12] = '{16'h3000, 2, 1'b0, 1'b1, 2'd3, 8'hFC}; // ADD R3,R0,R0 (wrap)

        resetn      = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_addr    = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {15'd0, instr_ready}, 16'd1);
        chk("rst_retire_valid", {15'd0, retire_valid}, 16'd0);
        chk("rst_alu_ab", {alu_a, alu_b}, 16'h0000);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {15'd0, instr_ready}, 16'd1);
        check_rf("rst_rf", 32'h0000_0000);

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i]);
        end
        check_rf("table_final_rf", 32'hFC02_01FE);

        // instr_valid held across busy cycles: A = ADD R0,R1,R2 (03), then B = ADD R3,R0,R0 (06)
        exp_rdy = 7'b1001001;
        acc  = 0;
        rets = 0;
        @(negedge clk);
        instr       = 16'h0600;
        instr_valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c == 1) instr = 16'h3000;
            if (c == 6) instr_valid = 1'b0;
            chk("hold_ready_pattern", {15'd0, instr_ready}, {15'd0, exp_rdy[c]});
            if (instr_valid && instr_ready) acc++;
            if (retire_valid) begin
                if (rets < 2) ret_d[rets] = retire_data;
                rets++;
            end
            @(negedge clk);
        end
        chk("hold_accepts", 16'(acc), 16'd2);
        chk("hold_retires", 16'(rets), 16'd2);
        chk("hold_ret_a", {8'd0, ret_d[0]}, 16'h0003);
        chk("hold_ret_b", {8'd0, ret_d[1]}, 16'h0006);
        check_rf("hold_rf", 32'h0602_0103);

        // Reset asserted during EXEC of ADD R3,R1,R2
        instr       = 16'h3600;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("midexec_ready", {15'd0, instr_ready}, 16'd0);
        resetn = 1'b0;
        #1;
        chk("midexec_rst_ready", {15'd0, instr_ready}, 16'd1);
        chk("midexec_rst_alu", {alu_a, alu_b}, 16'h0000);
        chk("midexec_rst_sub", {15'd0, alu_sub}, 16'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("post_rst_no_retire", {15'd0, retire_valid}, 16'd0);
            chk("post_rst_ready_hold", {15'd0, instr_ready}, 16'd1);
            @(negedge clk);
        end
        check_rf("post_rst_rf", 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
